nor_chain_tester: RTL and testbench

Sequential sweep-and-check engine for the 4-input cascaded NOR chain (E = ~(A|B), F = ~(E|C), G = ~(F|D)). On a start pulse it drives all 16 input vectors into the chain under test and samples its E/F/G outputs after a settle time. It compares each sample against an internal reference model, then reports the captured G truth table, a mismatch count and the first failing vector. It sits beside the chain on the lab board as the observing end of the chain's inputs and outputs.

---
 rtl/nor_chain_tester_if.sv | 37 +++
 rtl/nor_chain_tester.sv | 110 +++++++++++
 tb/tb_nor_chain_tester.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/nor_chain_tester_if.sv
// Bus between the NOR-chain sweep engine and the chain/board it observes.
//
// Handshake: start is a one-cycle request that the tester takes only in IDLE or
// DONE (it is ignored while a sweep runs); done is a level-valid flag that qualifies
// table_g/err_count/first_err_idx/err and stays high until the next start is taken.
// dut_e/f/g are sampled as-is.
interface nor_chain_tester_if;
    logic        start;
    logic        dut_e;
    logic        dut_f;
    logic        dut_g;
    logic        vec_a;
    logic        vec_b;
    logic        vec_c;
    logic        vec_d;
    logic        busy;
    logic        done;
    logic [15:0] table_g;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        err;
    logic [1:0]  dbg_state;

    // Tester side: drives the chain inputs and reports the results.
    modport master (
        input  start, dut_e, dut_f, dut_g,
        output vec_a, vec_b, vec_c, vec_d, busy, done,
               table_g, err_count, first_err_idx, err, dbg_state
    );

    // Environment side: issues start and presents the chain outputs.
    modport slave (
        output start, dut_e, dut_f, dut_g,
        input  vec_a, vec_b, vec_c, vec_d, busy, done,
               table_g, err_count, first_err_idx, err, dbg_state
    );
endinterface

// File: rtl/nor_chain_tester.sv
// Sweep-and-check engine for the cascaded NOR chain E=~(A|B), F=~(E|C), G=~(F|D).
// Drives all 16 input vectors, holds each for SETTLE cycles (legal 1..15), samples
// E/F/G on the last cycle and compares them with a built-in reference.
module nor_chain_tester #(
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    nor_chain_tester_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  errs_q, errs_d;
    logic [3:0]  first_q, first_d;

    logic e_exp, f_exp, g_exp, mismatch;

    // Reference chain response for the vector currently driven, and the compare.
    always_comb begin
        e_exp    = ~(idx_q[3] | idx_q[2]);
        f_exp    = ~(e_exp | idx_q[1]);
        g_exp    = ~(f_exp | idx_q[0]);
        mismatch = (bus.dut_e != e_exp) || (bus.dut_f != f_exp) || (bus.dut_g != g_exp);
    end

    // State and result registers; reset aborts any sweep without keeping partial results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            table_q <= 16'h0000;
            errs_q  <= 5'd0;
            first_q <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            errs_q  <= errs_d;
            first_q <= first_d;
        end
    end

    // Next-state: start clears results, RUN steps vectors and records each sample.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        errs_d  = errs_q;
        first_d = first_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    table_d = 16'h0000;
                    errs_d  = 5'd0;
                    first_d = 4'd0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    table_d[idx_q] = bus.dut_g;
                    if (mismatch) begin
                        // At most 16 increments from zero, so no wrap is possible.
                        errs_d = errs_q + 5'd1;
                        if (errs_q == 5'd0) begin
                            first_d = idx_q;
                        end
                    end
                    cnt_d = 4'd0;
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Chain inputs are only driven during a sweep.
    assign bus.vec_a         = (state_q == RUN) & idx_q[3];
    assign bus.vec_b         = (state_q == RUN) & idx_q[2];
    assign bus.vec_c         = (state_q == RUN) & idx_q[1];
    assign bus.vec_d         = (state_q == RUN) & idx_q[0];
    assign bus.busy          = (state_q == RUN);
    assign bus.done          = (state_q == DONE);
    assign bus.table_g       = table_q;
    assign bus.err_count     = errs_q;
    assign bus.first_err_idx = first_q;
    assign bus.err           = (errs_q != 5'd0);
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_nor_chain_tester.sv
// Bench for nor_chain_tester: a SETTLE=2 and a SETTLE=1 instance, each beside a
// behavioural NOR chain with injectable faults. Drivers push the expected sweep
// result when they issue start; a monitor pops and compares when done rises.
module tb_nor_chain_tester;
    typedef struct packed {
        logic [1:0]  e_mode;   // 0 healthy, 1 stuck-at-0, 2 stuck-at-1
        logic [1:0]  g_mode;
        logic [15:0] flip_f;   // per-vector inversion of F
    } fault_t;

    typedef struct packed {
        logic [3:0]  vec;
        logic        busy;
        logic        done;
        logic [15:0] table_g;
        logic [4:0]  err_count;
        logic [3:0]  first_idx;
        logic        err;
        logic [1:0]  state;
    } obs_t;

    localparam logic [25:0] GOLD = {16'h4445, 5'd0, 4'd0, 1'b0};

    logic   clk = 1'b0;
    logic   rst;
    logic   start_r [2];
    fault_t fc2, fc1;
    obs_t   ob [2];
    logic   done_prev [2];

    int checks = 0;
    int errors = 0;

    logic [25:0] exp_q0 [$];
    logic [25:0] exp_q1 [$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs and chain models ----------------
    nor_chain_tester_if bus2 ();
    nor_chain_tester_if bus1 ();

    nor_chain_tester #(.SETTLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    nor_chain_tester #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Behavioural chain: {E,F,G} for inputs i=ABCD, with faults applied.
    function automatic logic [2:0] chain_out(input logic [3:0] i, input fault_t fc);
        logic e, f, g;
        e = !(i[3] || i[2]);
        if (fc.e_mode == 2'd1) e = 1'b0;
        else if (fc.e_mode == 2'd2) e = 1'b1;
        f = !(e || i[1]);
        if (fc.flip_f[i]) f = !f;
        g = !(f || i[0]);
        if (fc.g_mode == 2'd1) g = 1'b0;
        else if (fc.g_mode == 2'd2) g = 1'b1;
        return {e, f, g};
    endfunction

    // Reference sweep result {table_g, err_count, first_err_idx, err}.
    function automatic logic [25:0] expect_result(input fault_t fc);
        logic [15:0] t;
        int          n;
        logic [3:0]  first;
        logic [2:0]  got, good;
        t = 16'h0; n = 0; first = 4'd0;
        for (int i = 0; i < 16; i++) begin
            got  = chain_out(4'(i), fc);
            good = chain_out(4'(i), '0);
            t[i] = got[0];
            if (got != good) begin
                if (n == 0) first = 4'(i);
                n++;
            end
        end
        return {t, 5'(n), first, (n != 0)};
    endfunction

    assign bus2.start = start_r[0];
    assign bus1.start = start_r[1];
    assign {bus2.dut_e, bus2.dut_f, bus2.dut_g} =
        chain_out({bus2.vec_a, bus2.vec_b, bus2.vec_c, bus2.vec_d}, fc2);
    assign {bus1.dut_e, bus1.dut_f, bus1.dut_g} =
        chain_out({bus1.vec_a, bus1.vec_b, bus1.vec_c, bus1.vec_d}, fc1);

    assign ob[0] = {bus2.vec_a, bus2.vec_b, bus2.vec_c, bus2.vec_d, bus2.busy, bus2.done,
                    bus2.table_g, bus2.err_count, bus2.first_err_idx, bus2.err, bus2.dbg_state};
    assign ob[1] = {bus1.vec_a, bus1.vec_b, bus1.vec_c, bus1.vec_d, bus1.busy, bus1.done,
                    bus1.table_g, bus1.err_count, bus1.first_err_idx, bus1.err, bus1.dbg_state};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        done_prev[0] = 1'b0;
        done_prev[1] = 1'b0;
    end

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (ob[s].done && !done_prev[s]) begin
                logic [25:0] e;
                int          qs;
                qs = (s == 0) ? exp_q0.size() : exp_q1.size();
                if (qs == 0) begin
                    check(s == 0 ? "unexpected_done_s2" : "unexpected_done_s1", 64'd1, 64'd0);
                end else begin
                    e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check(s == 0 ? "result_s2" : "result_s1",
                          {ob[s].table_g, ob[s].err_count, ob[s].first_idx, ob[s].err}, e);
                end
            end
            done_prev[s] = ob[s].done;
        end
    end

    // ---------------- driver ----------------
    // One sweep on instance s; checks vector pacing, busy, clear-on-start and done
    // latency. abort_at >= 0 pulses rst at that cycle of the sweep instead.
    task automatic run_sweep(input int s, input fault_t fc, input logic [25:0] exp,
                             input bit repulse, input int abort_at);
        int S;
        S = (s == 0) ? 2 : 1;
        if (s == 0) fc2 = fc; else fc1 = fc;
        @(negedge clk);
        start_r[s] = 1'b1;
        if (s == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        for (int j = 0; j < 16 * S; j++) begin
            @(negedge clk);
            start_r[s] = repulse && (j == 5 || j == 20);
            if (j == 0) begin
                check("cleared_on_start",
                      {ob[s].table_g, ob[s].err_count, ob[s].first_idx, ob[s].err}, 64'd0);
            end
            check("vec_step", {ob[s].busy, ob[s].done, ob[s].vec}, {2'b10, 4'(j / S)});
            if (j == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_reset_values", ob[s], 64'd0);
                if (s == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
                @(negedge clk);
                rst = 1'b0;
                start_r[s] = 1'b0;
                repeat (2) @(negedge clk);
                check("idle_after_abort", ob[s], 64'd0);
                return;
            end
        end
        @(negedge clk);
        start_r[s] = 1'b0;
        check("done_latency", {ob[s].busy, ob[s].done, ob[s].vec}, {2'b01, 4'd0});
        repeat (3) @(negedge clk);
        check("done_hold", {ob[s].done, ob[s].table_g, ob[s].err_count, ob[s].first_idx, ob[s].err},
              {1'b1, exp});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fault_t fr;
        rst = 1'b1;
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        fc2 = '0;
        fc1 = '0;
        repeat (3) @(negedge clk);
        check("reset_s2", ob[0], 64'd0);
        check("reset_s1", ob[1], 64'd0);
        rst = 1'b0;

        run_sweep(0, '0, GOLD, 1'b0, -1);
        fr = '0; fr.g_mode = 2'd1;
        run_sweep(0, fr, {16'h0000, 5'd5, 4'd0, 1'b1}, 1'b0, -1);
        fr = '0; fr.e_mode = 2'd2;
        run_sweep(0, fr, {16'h5555, 5'd12, 4'd4, 1'b1}, 1'b0, -1);
        run_sweep(0, '0, GOLD, 1'b1, -1);
        fr = '0; fr.g_mode = 2'd1;
        run_sweep(0, fr, {16'h0000, 5'd5, 4'd0, 1'b1}, 1'b0, 10);
        run_sweep(0, '0, GOLD, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            fr.e_mode = 2'($urandom_range(0, 2));
            fr.g_mode = 2'($urandom_range(0, 2));
            fr.flip_f = 16'($urandom & $urandom & $urandom);
            run_sweep(0, fr, expect_result(fr), 1'b0, -1);
        end

        run_sweep(1, '0, GOLD, 1'b0, -1);
        for (int r = 0; r < 2; r++) begin
            fr.e_mode = 2'($urandom_range(0, 2));
            fr.g_mode = 2'($urandom_range(0, 2));
            fr.flip_f = 16'($urandom & $urandom);
            run_sweep(1, fr, expect_result(fr), 1'b0, -1);
        end

        @(negedge clk);
        check("queue_drained_s2", 64'(exp_q0.size()), 64'd0);
        check("queue_drained_s1", 64'(exp_q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
